// File: rtl/wddl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wddl_pkg
// Description : Shared types and helpers for the WDDL dual-rail register bank.
//               - wddl_state_e : precharge/evaluation phase encoding
//               - SPACER       : dual-rail spacer value {t,f} = 0/0
//               - rail_fault() : a dual-rail bit is faulty when t == f
// Revision    : 1.0 - initial release
// ============================================================================
package wddl_pkg;

    // Phase of the free-running precharge/evaluation sequencer.
    typedef enum logic [0:0] {
        PRE  = 1'b0,
        EVAL = 1'b1
    } wddl_state_e;

    // Spacer value carried by both rails during precharge, packed as {t, f}.
    localparam logic [1:0] SPACER = 2'b00;

    // A valid WDDL bit is always complementary; equal rails mean either a
    // spacer leaking into evaluation (0/0) or a double-high fault (1/1).
    function automatic logic rail_fault(input logic t, input logic f);
        return (t == f);
    endfunction

endpackage : wddl_pkg
`default_nettype wire

// File: rtl/wddl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : wddl_sat_counter
// Description : Saturating up-counter. Increments by one on each cycle that
//               inc is high, sticks at its all-ones maximum and never wraps.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous active-high reset, clears count
//               inc   - increment request
//               count - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module wddl_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : wddl_sat_counter
`default_nettype wire

// File: rtl/wddl_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : wddl_reg_bank
// Description : WDDL dual-rail register bank with built-in precharge phase
//               sequencer and rail-integrity checker. Generates prechrg_o for
//               the surrounding WDDL gate arrays, captures WIDTH dual-rail bits
//               at the end of each evaluation phase, forces spacer 0/0 on its
//               outputs during precharge, and counts rail faults.
// Ports       : clk            - clock, rising edge
//               rst_i          - synchronous active-high reset
//               t_i / f_i      - true / false rails from upstream stage
//               in_valid_i     - upstream word settled and valid
//               in_ready_o     - bank captures this cycle if in_valid_i
//               prechrg_o      - 1 = precharge phase
//               q_t_o / q_f_o  - registered true / false rails
//               out_valid_o    - q_* hold a captured word this eval phase
//               err_mask_o     - per-bit fault vector of last captured word
//               eval_err_cnt_o - saturating count of faulty captured words
//               pre_err_cnt_o  - saturating count of leaky precharge cycles
// Revision    : 1.0 - initial release
// ============================================================================
module wddl_reg_bank
    import wddl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EVAL_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] t_i,
    input  logic [WIDTH-1:0] f_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             prechrg_o,
    output logic [WIDTH-1:0] q_t_o,
    output logic [WIDTH-1:0] q_f_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] err_mask_o,
    output logic [CNT_W-1:0] eval_err_cnt_o,
    output logic [CNT_W-1:0] pre_err_cnt_o
);

    localparam int EC_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
    localparam logic [EC_W-1:0]  LAST_EVAL = EC_W'(EVAL_CYCLES - 1);
    localparam logic [WIDTH-1:0] SPACER_T  = {WIDTH{SPACER[1]}};
    localparam logic [WIDTH-1:0] SPACER_F  = {WIDTH{SPACER[0]}};

    wddl_state_e      state;
    logic [EC_W-1:0]  eval_cnt;
    logic [EC_W-1:0]  eval_cnt_next;

    // Word held between the capture edge and the following evaluation phase.
    logic [WIDTH-1:0] stored_t;
    logic [WIDTH-1:0] stored_f;
    logic             stored_valid;

    logic [WIDTH-1:0] fault_vec;
    logic             last_eval;
    logic             capture;
    logic             pre_leak;

    // Per-bit complementarity check on the incoming rails.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fault
            assign fault_vec[i] = rail_fault(t_i[i], f_i[i]);
        end
    endgenerate

    assign eval_cnt_next = eval_cnt + EC_W'(1);

    // Decoded from the state registers rather than in_ready_o so the capture
    // qualifier does not depend on an output flop.
    assign last_eval = (state == EVAL) && (eval_cnt == LAST_EVAL);
    assign capture   = last_eval && in_valid_i;

    // Any high rail while the upstream gates should be precharged is a leak.
    assign pre_leak  = (state == PRE) && (|(t_i | f_i));

    // ------------------------------------------------------------------------
    // Phase sequencer, capture register and output gating.
    // All outputs are registered and loaded with the value they must present
    // in the cycle that the next state represents.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state        <= PRE;
            eval_cnt     <= '0;
            prechrg_o    <= 1'b1;
            in_ready_o   <= 1'b0;
            q_t_o        <= '0;
            q_f_o        <= '0;
            out_valid_o  <= 1'b0;
            err_mask_o   <= '0;
            stored_t     <= '0;
            stored_f     <= '0;
            stored_valid <= 1'b0;
        end else begin
            case (state)
                PRE: begin
                    // Single precharge cycle, then open the evaluation phase
                    // presenting whatever was captured at the previous end of
                    // evaluation, or spacer if nothing was.
                    state       <= EVAL;
                    eval_cnt    <= '0;
                    prechrg_o   <= 1'b0;
                    in_ready_o  <= (EVAL_CYCLES == 1);
                    q_t_o       <= stored_valid ? stored_t : SPACER_T;
                    q_f_o       <= stored_valid ? stored_f : SPACER_F;
                    out_valid_o <= stored_valid;
                end

                EVAL: begin
                    if (last_eval) begin
                        state        <= PRE;
                        eval_cnt     <= '0;
                        prechrg_o    <= 1'b1;
                        in_ready_o   <= 1'b0;
                        q_t_o        <= SPACER_T;
                        q_f_o        <= SPACER_F;
                        out_valid_o  <= 1'b0;
                        // A missing word invalidates the store so the next
                        // evaluation phase emits spacer.
                        stored_valid <= capture;
                        if (capture) begin
                            // Faulty bits are neutralised to spacer so a bad
                            // rail pair never propagates downstream.
                            stored_t   <= t_i & ~fault_vec;
                            stored_f   <= f_i & ~fault_vec;
                            err_mask_o <= fault_vec;
                        end else begin
                            stored_t   <= SPACER_T;
                            stored_f   <= SPACER_F;
                        end
                    end else begin
                        eval_cnt   <= eval_cnt_next;
                        in_ready_o <= (eval_cnt_next == LAST_EVAL);
                    end
                end

                default: begin
                    state <= PRE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Fault counters
    // ------------------------------------------------------------------------
    wddl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_eval_err_cnt (
        .clk   (clk),
        .rst   (rst_i),
        .inc   (capture && (|fault_vec)),
        .count (eval_err_cnt_o)
    );

    wddl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_pre_err_cnt (
        .clk   (clk),
        .rst   (rst_i),
        .inc   (pre_leak),
        .count (pre_err_cnt_o)
    );

endmodule : wddl_reg_bank
`default_nettype wire

// File: tb/tb_wddl_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_wddl_reg_bank
// Description : Self-checking bench for wddl_reg_bank. Instance A uses
//               EVAL_CYCLES=1, CNT_W=2 (phase toggling, capture, faults,
//               saturation, reset priority); instance B uses EVAL_CYCLES=3
//               (ready placement, hold across evaluation, dropped word).
//               Captured words are pushed to a scoreboard queue when driven
//               and popped when the bank presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wddl_reg_bank;

    typedef struct packed {
        logic [7:0] t;
        logic [7:0] f;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, EVAL_CYCLES=1, CNT_W=2
    logic       rst_a, valid_a, ready_a, pre_a, ov_a;
    logic [7:0] t_a, f_a, qt_a, qf_a, mask_a;
    logic [1:0] ecnt_a, pcnt_a;

    // Instance B: WIDTH=8, EVAL_CYCLES=3, CNT_W=8
    logic       rst_b, valid_b, ready_b, pre_b, ov_b;
    logic [7:0] t_b, f_b, qt_b, qf_b, mask_b, ecnt_b, pcnt_b;

    wddl_reg_bank #(.WIDTH(8), .EVAL_CYCLES(1), .CNT_W(2)) dut_a (
        .clk            (clk),
        .rst_i          (rst_a),
        .t_i            (t_a),
        .f_i            (f_a),
        .in_valid_i     (valid_a),
        .in_ready_o     (ready_a),
        .prechrg_o      (pre_a),
        .q_t_o          (qt_a),
        .q_f_o          (qf_a),
        .out_valid_o    (ov_a),
        .err_mask_o     (mask_a),
        .eval_err_cnt_o (ecnt_a),
        .pre_err_cnt_o  (pcnt_a)
    );

    wddl_reg_bank #(.WIDTH(8), .EVAL_CYCLES(3), .CNT_W(8)) dut_b (
        .clk            (clk),
        .rst_i          (rst_b),
        .t_i            (t_b),
        .f_i            (f_b),
        .in_valid_i     (valid_b),
        .in_ready_o     (ready_b),
        .prechrg_o      (pre_b),
        .q_t_o          (qt_b),
        .q_f_o          (qf_b),
        .out_valid_o    (ov_b),
        .err_mask_o     (mask_b),
        .eval_err_cnt_o (ecnt_b),
        .pre_err_cnt_o  (pcnt_b)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    word_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] fmask(input logic [7:0] t, input logic [7:0] f);
        return ~(t ^ f);
    endfunction

    task automatic push_exp(input logic [7:0] t, input logic [7:0] f);
        logic [7:0] m;
        m = fmask(t, f);
        sb_q.push_back({t & ~m, f & ~m});
    endtask

    task automatic pop_exp(input string tag, output word_t w, output bit ok);
        ok = 1'b0;
        w  = '0;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty got 0 expected 1 entry", tag);
        end else begin
            w  = sb_q.pop_front();
            ok = 1'b1;
        end
    endtask

    // Instance A, called in an EVAL (ready) cycle; returns in the following
    // EVAL cycle with the captured word checked on q_*.
    task automatic cap_a(input logic [7:0] t, input logic [7:0] f, input logic [1:0] exp_cnt);
        word_t w;
        bit    ok;
        chk("a_ready_cap", ready_a, 1);
        t_a = t; f_a = f; valid_a = 1'b1;
        push_exp(t, f);
        step();
        t_a = '0; f_a = '0; valid_a = 1'b0;
        chk("a_pre_prechrg", pre_a, 1);
        chk("a_pre_qt", qt_a, 0);
        chk("a_pre_qf", qf_a, 0);
        chk("a_pre_ov", ov_a, 0);
        chk("a_err_mask", mask_a, fmask(t, f));
        chk("a_eval_err_cnt", ecnt_a, exp_cnt);
        step();
        pop_exp("a_sb", w, ok);
        if (ok) begin
            chk("a_ov", ov_a, 1);
            chk("a_qt", qt_a, w.t);
            chk("a_qf", qf_a, w.f);
        end
    endtask

    initial begin
        word_t w;
        bit    ok;
        rst_a = 1'b1; t_a = '0; f_a = '0; valid_a = 1'b0;
        rst_b = 1'b1; t_b = '0; f_b = '0; valid_b = 1'b0;

        // ---------------- Instance A: reset and phase toggling ---------------
        repeat (2) step();
        rst_a = 1'b0;
        chk("a_rst_prechrg", pre_a, 1);
        chk("a_rst_ready", ready_a, 0);
        chk("a_rst_qt", qt_a, 0);
        chk("a_rst_qf", qf_a, 0);
        chk("a_rst_ov", ov_a, 0);
        chk("a_rst_mask", mask_a, 0);
        chk("a_rst_ecnt", ecnt_a, 0);
        chk("a_rst_pcnt", pcnt_a, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("a_toggle", pre_a, (k % 2 == 1));
            chk("a_toggle_ready", ready_a, (k % 2 == 0));
        end
        step();  // into EVAL

        // ---------------- Clean and faulty captures --------------------------
        cap_a(8'hA5, 8'h5A, 2'd0);
        cap_a(8'hFF, 8'h0E, 2'd1);

        // No capture: next EVAL shows spacer, mask holds
        step();
        step();
        chk("a_drop_ov", ov_a, 0);
        chk("a_drop_qt", qt_a, 0);
        chk("a_drop_qf", qf_a, 0);
        chk("a_drop_mask", mask_a, 8'h0E);

        // Eval-error counter saturation at 3; mask still updates
        cap_a(8'hF0, 8'h0E, 2'd2);
        cap_a(8'h3C, 8'hC0, 2'd3);
        cap_a(8'h55, 8'hAB, 2'd3);

        // ---------------- Precharge leak with saturation ---------------------
        t_a = 8'h01;
        for (int k = 1; k <= 5; k++) begin
            step();  // PRE with a rail high
            step();  // counter visible after the edge ending PRE
            chk("a_pre_leak", pcnt_a, (k < 3) ? k : 3);
        end
        t_a = '0;

        // ---------------- Reset has priority over capture --------------------
        chk("a_ready_rst", ready_a, 1);
        t_a = 8'hA5; f_a = 8'h5A; valid_a = 1'b1; rst_a = 1'b1;
        step();
        rst_a = 1'b0; t_a = '0; f_a = '0; valid_a = 1'b0;
        chk("a_rst2_prechrg", pre_a, 1);
        chk("a_rst2_ready", ready_a, 0);
        chk("a_rst2_mask", mask_a, 0);
        chk("a_rst2_ecnt", ecnt_a, 0);
        chk("a_rst2_pcnt", pcnt_a, 0);
        step();
        chk("a_rst2_eval_prechrg", pre_a, 0);
        chk("a_rst2_eval_ov", ov_a, 0);
        chk("a_rst2_eval_qt", qt_a, 0);
        chk("a_rst2_eval_qf", qf_a, 0);
        chk("a_sb_empty", sb_q.size(), 0);

        // ---------------- Instance B: EVAL_CYCLES=3 --------------------------
        rst_b = 1'b0;  // current cycle is the first PRE after release
        chk("b_rst_prechrg", pre_b, 1);
        chk("b_rst_ready", ready_b, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("b_period_prechrg", pre_b, (k % 4 == 0));
            chk("b_period_ready", ready_b, (k % 4 == 3));
        end
        repeat (3) step();  // EVAL2
        chk("b_ready_cap", ready_b, 1);
        t_b = 8'hC3; f_b = 8'h3C; valid_b = 1'b1;
        push_exp(8'hC3, 8'h3C);
        step();
        t_b = '0; f_b = '0; valid_b = 1'b0;
        chk("b_pre_ov", ov_b, 0);
        chk("b_pre_qt", qt_b, 0);
        chk("b_mask", mask_b, 0);
        pop_exp("b_sb", w, ok);
        for (int k = 0; k < 3; k++) begin
            step();
            if (ok) begin
                chk("b_hold_ov", ov_b, 1);
                chk("b_hold_qt", qt_b, w.t);
                chk("b_hold_qf", qf_b, w.f);
            end
            chk("b_hold_ready", ready_b, (k == 2));
        end
        // valid_b stays low across this ready cycle: dropped word
        step();
        chk("b_drop_pre_prechrg", pre_b, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("b_drop_ov", ov_b, 0);
            chk("b_drop_qt", qt_b, 0);
            chk("b_drop_qf", qf_b, 0);
        end
        chk("b_ecnt", ecnt_b, 0);
        chk("b_pcnt", pcnt_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wddl_reg_bank
`default_nettype wire
